fifo_stream_out: RTL and testbench



---
 rtl/fifo_stream_out.sv | 82 ++++++++
 tb/tb_fifo_stream_out.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_out.sv
// Read-side drain of the async FIFO: turns rd_en/empty/data into a valid/ready
// stream through a 3-entry skid buffer and tags the last beat of each burst.
module fifo_stream_out #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = $clog2(BURST_LEN) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [1:0]            occupancy
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BURST_LEN - 1);

    logic [DATA_WIDTH-1:0] skid_q [3];
    logic [1:0]            occ_q;
    logic                  inflight_q;
    logic [CNT_WIDTH-1:0]  count_q;

    logic       acc;
    logic       pop;
    logic       capture;
    logic [1:0] wr_idx;
    logic [2:0] credit;

    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = skid_q[0];
    assign m_last    = m_valid & (count_q == LAST_CNT);
    assign occupancy = occ_q;

    // Credit counts words already buffered plus the one still in flight, so a
    // read is only issued when its data is guaranteed a free slot.
    always_comb begin
        credit     = {1'b0, occ_q} + {2'b00, inflight_q};
        fifo_rd_en = ~rst & ~fifo_empty & ~flush & (credit <= 3'd2);
        acc        = fifo_rd_en & ~fifo_empty;
        pop        = m_valid & m_ready;
        capture    = inflight_q & ~flush;
        wr_idx     = occ_q - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                skid_q[i] <= '0;
            end
        end else begin
            inflight_q <= acc;
            if (flush) begin
                occ_q   <= '0;
                count_q <= '0;
            end else begin
                if (pop) begin
                    skid_q[0] <= skid_q[1];
                    skid_q[1] <= skid_q[2];
                end
                // Write lands behind whatever survives this cycle's pop.
                for (int unsigned i = 0; i < 3; i++) begin
                    if (capture && (wr_idx == 2'(i))) begin
                        skid_q[i] <= fifo_data;
                    end
                end
                occ_q <= occ_q + {1'b0, capture} - {1'b0, pop};
                if (pop) begin
                    count_q <= (count_q == LAST_CNT) ? '0 : count_q + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_out.sv
// Directed bench for fifo_stream_out: behavioural FIFO source, beat monitor,
// and immediate-assertion checks against hand-computed expectations.
module tb_fifo_stream_out;

    localparam int DW = 8;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [1:0]    occupancy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_stream_out #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .occupancy  (occupancy)
    );

    // Source FIFO model: one-cycle read latency.
    logic [DW-1:0] mem [0:63];
    int wr_ptr   = 0;
    int rd_ptr   = 0;
    int rd_count = 0;
    int cyc      = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr[5:0]];
            rd_ptr    <= rd_ptr + 1;
            rd_count  <= rd_count + 1;
        end
    end

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            c;
    } beat_t;

    beat_t beats[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: records transfers and checks output stability under stall.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        if (prev_stall && !rst) begin
            chk("hold_valid", {31'd0, m_valid}, 32'd1);
            chk("hold_data", {24'd0, m_data}, {24'd0, prev_data});
        end
        prev_stall = m_valid && !m_ready && !rst && !flush;
        prev_data  = m_data;
        if (m_valid && m_ready && !rst) beats.push_back('{m_data, m_last, cyc});
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr++;
    endtask

    task automatic check_beats(input string tag, input int n, input int first);
        chk({tag, "_count"}, beats.size(), n);
        for (int i = 0; i < n && i < beats.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), {24'd0, beats[i].d}, first + i);
            chk($sformatf("%s_last%0d", tag, i), {31'd0, beats[i].l}, (i % BL) == (BL - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        rst     = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        tick(2);
        chk("rst_occ",   {30'd0, occupancy}, 0);
        chk("rst_valid", {31'd0, m_valid}, 0);
        chk("rst_last",  {31'd0, m_last}, 0);
        chk("rst_data",  {24'd0, m_data}, 0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 0);
        rst = 1'b0;
        tick();

        // 1: single word, two-cycle latency, one-cycle beat.
        m_ready = 1'b1;
        beats.delete();
        push(8'hA5);
        #1;
        chk("t1_rd_en", {31'd0, fifo_rd_en}, 1);
        tick();
        chk("t1_valid_c1", {31'd0, m_valid}, 0);
        tick();
        chk("t1_valid_c2", {31'd0, m_valid}, 1);
        chk("t1_data", {24'd0, m_data}, 32'hA5);
        chk("t1_last", {31'd0, m_last}, 0);
        tick();
        chk("t1_valid_c3", {31'd0, m_valid}, 0);
        chk("t1_occ", {30'd0, occupancy}, 0);
        chk("t1_beats", beats.size(), 1);

        flush = 1'b1;
        tick();
        flush = 1'b0;

        // 2: streaming 8 words, no bubbles, m_last every 4th beat.
        beats.delete();
        for (int i = 1; i <= 8; i++) push(DW'(i));
        tick(14);
        check_beats("stream", 8, 1);
        for (int i = 1; i < 8 && i < beats.size(); i++)
            chk($sformatf("stream_gap%0d", i), beats[i].c - beats[i-1].c, 1);

        // 3: backpressure, exactly three reads outstanding.
        m_ready = 1'b0;
        base = rd_count;
        beats.delete();
        for (int i = 0; i < 10; i++) push(DW'(8'h10 + i));
        tick(8);
        chk("bp_reads", rd_count - base, 3);
        chk("bp_occ", {30'd0, occupancy}, 3);
        chk("bp_rd_en", {31'd0, fifo_rd_en}, 0);
        chk("bp_valid", {31'd0, m_valid}, 1);
        chk("bp_head", {24'd0, m_data}, 32'h10);
        m_ready = 1'b1;
        tick(20);
        check_beats("bp", 10, 8'h10);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // 4: empty gap, burst count carried across it.
        beats.delete();
        push(8'h20);
        push(8'h21);
        tick(4);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("gap_valid%0d", i), {31'd0, m_valid}, 0);
            tick();
        end
        push(8'h22);
        push(8'h23);
        tick(6);
        check_beats("gap", 4, 8'h20);

        // 5: flush with occupancy 2 and a read in flight.
        push(8'h50);
        tick(4);
        beats.delete();
        m_ready = 1'b0;
        push(8'h51);
        push(8'h52);
        push(8'h53);
        tick(3);
        chk("fl_occ_pre", {30'd0, occupancy}, 2);
        flush = 1'b1;
        for (int i = 0; i < 4; i++) push(DW'(8'h60 + i));
        #1;
        chk("fl_rd_en", {31'd0, fifo_rd_en}, 0);
        tick();
        flush = 1'b0;
        chk("fl_occ", {30'd0, occupancy}, 0);
        chk("fl_valid", {31'd0, m_valid}, 0);
        m_ready = 1'b1;
        tick(10);
        check_beats("flush", 4, 8'h60);

        // 6: reset after two beats of a burst.
        beats.delete();
        for (int i = 0; i < 8; i++) push(DW'(8'h70 + i));
        tick(4);
        chk("rb_pre_beats", beats.size(), 2);
        rst = 1'b1;
        #1;
        chk("rb_valid", {31'd0, m_valid}, 0);
        chk("rb_rd_en", {31'd0, fifo_rd_en}, 0);
        chk("rb_occ",   {30'd0, occupancy}, 0);
        beats.delete();
        tick(2);
        rst = 1'b0;
        tick(12);
        check_beats("rst", 4, 8'h74);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
